// File: rtl/pri_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pri_enc_pkg
//  Description : Shared widths, constants and state encoding for the
//                sequential pending-register priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pri_enc_pkg;

  localparam int unsigned N_REGS = 32;
  localparam int unsigned IDX_W  = $clog2(N_REGS);

  // Register zero is hardwired, so its pending bit is always discarded.
  localparam logic [N_REGS-1:0] ZERO_REG_MASK = {{(N_REGS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage : pri_enc_pkg
`default_nettype wire

// File: rtl/lsb_pri_enc.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_pri_enc
//  Description : Combinational lowest-set-bit encoder with an "any" flag.
//                Index is zero when no bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_pri_enc
  import pri_enc_pkg::*;
#(
  parameter int unsigned N = N_REGS,
  parameter int unsigned W = IDX_W
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = W'(i);
      end
    end
    any = |mask;
  end

endmodule : lsb_pri_enc
`default_nettype wire

// File: rtl/pri_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pri_enc_seq
//  Description : Sequential priority encoder. Accepts a pending-register
//                mask and emits the set register indices lowest-first, one
//                per ready/valid handshake. Register zero is never emitted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pri_enc_seq
  import pri_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_REGS-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [IDX_W:0]    beats_left
);

  state_t              state_r;
  state_t              state_nxt;
  logic [N_REGS-1:0]   mask_r;
  logic [N_REGS-1:0]   mask_nxt;
  logic [N_REGS-1:0]   mask_in_clr;
  logic [N_REGS-1:0]   lsb_onehot;
  logic [IDX_W-1:0]    lsb_idx;
  logic                lsb_any;
  logic [IDX_W:0]      pop_cnt;

  lsb_pri_enc #(
    .N (N_REGS),
    .W (IDX_W)
  ) u_lsb_pri_enc (
    .mask (mask_r),
    .idx  (lsb_idx),
    .any  (lsb_any)
  );

  // Count the bits still held; the mask is zero in IDLE so this reads zero.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N_REGS; i++) begin
      pop_cnt = pop_cnt + {{IDX_W{1'b0}}, mask_r[i]};
    end
  end

  // Output beat is purely a function of the held registers.
  always_comb begin
    out_valid  = (state_r == SCAN);
    out_idx    = lsb_idx;
    out_last   = lsb_any && (pop_cnt == {{IDX_W{1'b0}}, 1'b1});
    beats_left = pop_cnt;
    in_ready   = (state_r == IDLE) && !flush;
  end

  // Next-state and next-mask selection; flush takes precedence over all.
  always_comb begin
    state_nxt   = state_r;
    mask_nxt    = mask_r;
    mask_in_clr = in_mask & ~ZERO_REG_MASK;
    lsb_onehot  = ZERO_REG_MASK << lsb_idx;
    if (flush) begin
      state_nxt = IDLE;
      mask_nxt  = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mask_nxt = mask_in_clr;
            if (mask_in_clr != '0) begin
              state_nxt = SCAN;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            mask_nxt = mask_r & ~lsb_onehot;
            if (out_last) begin
              state_nxt = IDLE;
              mask_nxt  = '0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          mask_nxt  = '0;
        end
      endcase
    end
  end

  // State and held-mask registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mask_r  <= '0;
    end else begin
      state_r <= state_nxt;
      mask_r  <= mask_nxt;
    end
  end

endmodule : pri_enc_seq
`default_nettype wire

// File: tb/tb_pri_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pri_enc_seq
//  Description : Self-checking bench for pri_enc_seq. A queue of pending
//                indices models the block; directed vectors with literal
//                expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pri_enc_seq;
  import pri_enc_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [N_REGS-1:0] in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic [IDX_W:0]    beats_left;

  int n_checks = 0;
  int n_fail   = 0;

  int pend_q[$];

  pri_enc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .beats_left (beats_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the block holds the list of register indices still to emit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
    end else if (flush) begin
      pend_q.delete();
    end else if (pend_q.size() == 0) begin
      if (in_valid) begin
        for (int i = 1; i < N_REGS; i++) begin
          if (in_mask[i]) pend_q.push_back(i);
        end
      end
    end else if (out_ready) begin
      void'(pend_q.pop_front());
    end
  end

  // Every cycle, away from the edge, compare the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("m_out_valid", 32'(out_valid), 32'(pend_q.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'((pend_q.size() == 0) && !flush));
      chk("m_beats_left", 32'(beats_left), 32'(pend_q.size()));
      chk("m_out_last", 32'(out_last), 32'(pend_q.size() == 1));
      if (pend_q.size() != 0) begin
        chk("m_out_idx", 32'(out_idx), 32'(pend_q[0]));
      end
    end
  end

  // Advance to a point between the compare and the next rising edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic lit(input string tag, input logic v, input int idx, input logic last, input int beats);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_beats"}, 32'(beats_left), 32'(beats));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    #3;
    lit("reset", 1'b0, 0, 1'b0, 0);
    chk("reset_idx", 32'(out_idx), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Two-bit mask drained with out_ready held high.
    in_valid = 1'b1; in_mask = 32'h0000_000A; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lit("t1_b0", 1'b1, 1, 1'b0, 2);
    tick();
    lit("t1_b1", 1'b1, 3, 1'b1, 1);
    tick();
    lit("t1_done", 1'b0, 0, 1'b0, 0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // Only register zero pending: swallowed silently.
    in_valid = 1'b1; in_mask = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    lit("t2_a", 1'b0, 0, 1'b0, 0);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    tick();
    lit("t2_b", 1'b0, 0, 1'b0, 0);

    // Top register with a stalled consumer.
    out_ready = 1'b0; in_valid = 1'b1; in_mask = 32'h8000_0000;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      lit("t3_stall", 1'b1, 31, 1'b1, 1);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    lit("t3_stall_end", 1'b1, 31, 1'b1, 1);
    out_ready = 1'b1;
    tick();
    lit("t3_done", 1'b0, 0, 1'b0, 0);

    // Full mask: 31 back-to-back beats.
    in_valid = 1'b1; in_mask = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 32; i++) begin
      lit("t4_beat", 1'b1, i, (i == 31), 32 - i);
      tick();
    end
    lit("t4_done", 1'b0, 0, 1'b0, 0);

    // Flush in the middle of a mask, then flush blocks a new mask.
    in_valid = 1'b1; in_mask = 32'h0000_00F0;
    tick();
    in_valid = 1'b0;
    lit("t5_b4", 1'b1, 4, 1'b0, 4);
    tick();
    lit("t5_b5", 1'b1, 5, 1'b0, 3);
    tick();
    lit("t5_b6", 1'b1, 6, 1'b0, 2);
    flush = 1'b1;
    tick();
    lit("t5_flushed", 1'b0, 0, 1'b0, 0);
    chk("t5_in_ready_flush", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_mask = 32'h0000_0004;
    tick();
    lit("t5_blocked", 1'b0, 0, 1'b0, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    lit("t5_idle", 1'b0, 0, 1'b0, 0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-SCAN.
    out_ready = 1'b0; in_valid = 1'b1; in_mask = 32'h0000_000C;
    tick();
    in_valid = 1'b0;
    lit("t6_scan", 1'b1, 2, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    lit("t6_async", 1'b0, 0, 1'b0, 0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    lit("t6_after", 1'b0, 0, 1'b0, 0);
    chk("t6_in_ready_after", 32'(in_ready), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pri_enc_seq
`default_nettype wire
